// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// word/byte addressing constants and an index-width helper.
package mips_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Bytes per memory word and the lowest byte-address bit used for indexing
  localparam int WORD_BYTES   = 4;
  localparam int DMEM_IDX_LSB = $clog2(WORD_BYTES);

  // Number of word-index bits needed to address a DEPTH-word array
  function automatic int dmem_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request/response bus between the core (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
  parameter int AW = 32
);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with write enable and a synchronous
// clear of every word. Read data is registered and holds until the next read.
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                             CLK,
  input  logic                             clear,
  input  logic                             en,
  input  logic                             we,
  input  logic [dmem_idx_width(DEPTH)-1:0] idx,
  input  logic [31:0]                      wdata,
  output logic [31:0]                      rdata
);

  logic [31:0] mem [DEPTH];

  // Clear all words, or perform one write or one registered read per cycle
  always_ff @(posedge CLK) begin
    if (clear) begin
      // NOTE: clearing every word in one cycle forces the array into flops;
      // a block RAM cannot be reset, so this is only acceptable because the
      // responder must come out of reset with an all-zero memory.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the core's load/store port.
// Accepts one word request, waits LATENCY cycles, performs the access on
// entry to RESP and holds the response until the initiator consumes it.
// Optional: define DMEM_BOUNDS_CHECK_EN to fault misaligned or
// out-of-range addresses (store suppressed, load data 0, rsp_err=1).
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int AW      = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  dmem_responder_if.slave   bus
);

  localparam int         IW      = dmem_idx_width(DEPTH);
  localparam int         IDX_MSB = DMEM_IDX_LSB + IW - 1;
  localparam logic [3:0] LAT     = 4'(LATENCY);

  dmem_state_e   state;
  dmem_state_e   state_nx;
  logic [3:0]    cnt;
  logic          fire;

  // Request fields captured at acceptance, used when the access happens later
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;

  // Request fields actually presented to the array on the access cycle
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_fault;

  // Response qualifiers captured with the access
  logic          rsp_load;
  logic          rsp_fault;
  logic [31:0]   ram_rdata;

  // State register
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values regardless of block ordering.
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; fire marks the edge on which the memory access occurs
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned, which
    // would otherwise infer a latch.
    state_nx = state;
    fire     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            state_nx = RESP;
            fire     = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nx = RESP;
          fire     = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Zero-latency accesses use the live request; delayed ones use the latch
  always_comb begin
    acc_we    = lat_we;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  assign acc_fault = (acc_addr[DMEM_IDX_LSB-1:0] != '0) ||
                     (acc_addr[AW-1:IDX_MSB+1] != '0);
`else
  // Byte offset and bits above the index are ignored: accesses wrap
  assign acc_fault = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[DMEM_IDX_LSB-1:0], acc_addr[AW-1:IDX_MSB+1]};
`endif

  // Request latch, wait counter and response qualifiers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_load  <= 1'b0;
      rsp_fault <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        cnt       <= LAT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (fire) begin
        rsp_load  <= !acc_we && !acc_fault;
        rsp_fault <= acc_fault;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .CLK   (CLK),
    .clear (Reset),
    .en    (fire && !acc_fault),
    .we    (acc_we),
    .idx   (acc_addr[IDX_MSB:DMEM_IDX_LSB]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // Handshake and response outputs decoded from the state
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.rsp_rdata = (state == RESP && rsp_load) ? ram_rdata : 32'd0;
    bus.rsp_err   = (state == RESP) && rsp_fault;
  end

endmodule
